seg_msg_renderer: RTL and testbench

Parametrised seven-segment message renderer that turns a `msg_t` request into per-digit `seg_symbol_t` codes for a `DIGITS`-wide display. It supports static, blinking and scrolling presentation, and a live BCD pass-through for the stopwatch readout. It sits between the game FSM (`game_state_t` controller) and the board segment pins.

---
 rtl/datatype_package.sv | 96 +++++++++
 rtl/seg_tick_gen.sv | 29 ++
 rtl/seg_msg_renderer.sv | 148 ++++++++++++++
 tb/tb_seg_msg_renderer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/datatype_package.sv
// Shared display types: segment symbols, message IDs, presentation modes and the
// message text ROM used by the seven-segment renderer.
package datatype_package;

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}.
    typedef enum logic [6:0] {
        SEG_0    = 7'b1000000,
        SEG_1    = 7'b1111001,
        SEG_2    = 7'b0100100,
        SEG_3    = 7'b0110000,
        SEG_4    = 7'b0011001,
        SEG_5    = 7'b0010010,
        SEG_6    = 7'b0000010,
        SEG_7    = 7'b1111000,
        SEG_8    = 7'b0000000,
        SEG_9    = 7'b0010000,
        SEG_A    = 7'b0001000,
        SEG_E    = 7'b0000110,
        SEG_G    = 7'b1000010,
        SEG_P    = 7'b0001100,
        SEG_R    = 7'b0101111,
        SEG_T    = 7'b0000111,
        SEG_U    = 7'b1000001,
        SEG_DASH = 7'b0111111,
        SEG_OFF  = 7'b1111111
    } seg_symbol_t;

    typedef enum logic [2:0] {
        EMPTY,
        WELCOME,
        READY,
        WIN,
        STOPWATCH_MSG
    } msg_t;

    typedef enum logic [1:0] {
        MODE_STATIC,
        MODE_BLINK,
        MODE_SCROLL
    } disp_mode_t;

    typedef enum logic [1:0] {
        IDLE_R,
        SHOW_R,
        BLINK_R,
        SCROLL_R
    } render_state_t;

    localparam int MSG_MAX_LEN = 8;

    typedef seg_symbol_t msg_text_t [MSG_MAX_LEN];

    localparam msg_text_t WELCOME_TEXT = '{SEG_G, SEG_E, SEG_T, SEG_OFF, SEG_U, SEG_P, SEG_OFF, SEG_OFF};
    localparam msg_text_t READY_TEXT   = '{SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_OFF, SEG_OFF};
    localparam msg_text_t WIN_TEXT     = '{SEG_G, SEG_R, SEG_E, SEG_A, SEG_T, SEG_OFF, SEG_OFF, SEG_OFF};

    localparam logic [3:0] EMPTY_LEN   = 4'd0;
    localparam logic [3:0] WELCOME_LEN = 4'd6;
    localparam logic [3:0] READY_LEN   = 4'd6;
    localparam logic [3:0] WIN_LEN     = 4'd5;

    function automatic seg_symbol_t bcd_to_seg(input logic [3:0] bcd);
        case (bcd)
            4'd0:    bcd_to_seg = SEG_0;
            4'd1:    bcd_to_seg = SEG_1;
            4'd2:    bcd_to_seg = SEG_2;
            4'd3:    bcd_to_seg = SEG_3;
            4'd4:    bcd_to_seg = SEG_4;
            4'd5:    bcd_to_seg = SEG_5;
            4'd6:    bcd_to_seg = SEG_6;
            4'd7:    bcd_to_seg = SEG_7;
            4'd8:    bcd_to_seg = SEG_8;
            4'd9:    bcd_to_seg = SEG_9;
            default: bcd_to_seg = SEG_DASH;
        endcase
    endfunction

    function automatic logic [3:0] msg_len(input msg_t msg);
        case (msg)
            WELCOME: msg_len = WELCOME_LEN;
            READY:   msg_len = READY_LEN;
            WIN:     msg_len = WIN_LEN;
            default: msg_len = EMPTY_LEN;
        endcase
    endfunction

    function automatic seg_symbol_t msg_char(input msg_t msg, input logic [2:0] idx);
        case (msg)
            WELCOME: msg_char = WELCOME_TEXT[idx];
            READY:   msg_char = READY_TEXT[idx];
            WIN:     msg_char = WIN_TEXT[idx];
            default: msg_char = SEG_OFF;
        endcase
    endfunction

endpackage

// File: rtl/seg_tick_gen.sv
// Free-running animation tick: one-cycle pulse every TICK_DIV cycles, restartable
// by clr_i so the first tick lands TICK_DIV cycles after a clear.
module seg_tick_gen #(
    parameter int TICK_DIV = 12_500_000
) (
    input  logic clk_i,
    input  logic srst_i,
    input  logic clr_i,
    output logic tick_o
);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (srst_i || clr_i) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/seg_msg_renderer.sv
// Seven-segment message renderer: static, blinking and scrolling text plus a live
// BCD stopwatch readout, all with registered per-digit segment outputs.
module seg_msg_renderer
    import datatype_package::*;
#(
    parameter int DIGITS   = 6,
    parameter int TICK_DIV = 12_500_000
) (
    input  logic                clk_i,
    input  logic                srst_i,
    input  msg_t                msg_i,
    input  disp_mode_t          mode_i,
    input  logic                load_i,
    input  logic [4*DIGITS-1:0] bcd_i,
    output logic [7*DIGITS-1:0] seg_o,
    output logic                busy_o,
    output logic                wrap_o
);
    localparam int PW = $clog2(MSG_MAX_LEN + 2 * DIGITS);
    typedef logic [PW-1:0] pos_t;

    render_state_t       state_q, state_d;
    msg_t                msg_q, msg_d;
    pos_t                pos_q, pos_d;
    pos_t                last_pos;
    logic                visible_q, visible_d;
    logic                wrap_d;
    logic                tick;
    logic [7*DIGITS-1:0] seg_d;

    seg_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk_i (clk_i),
        .srst_i(srst_i),
        .clr_i (load_i),
        .tick_o(tick)
    );

    // Stopwatch never scrolls; EMPTY is blank whatever the mode.
    function automatic render_state_t state_for(input msg_t msg, input disp_mode_t mode);
        if (msg == EMPTY) begin
            state_for = IDLE_R;
        end else if (mode == MODE_BLINK) begin
            state_for = BLINK_R;
        end else if (mode == MODE_SCROLL && msg != STOPWATCH_MSG) begin
            state_for = SCROLL_R;
        end else begin
            state_for = SHOW_R;
        end
    endfunction

    function automatic seg_symbol_t render_digit(
        input render_state_t st,
        input msg_t          msg,
        input logic          visible,
        input pos_t          pos,
        input logic [3:0]    bcd,
        input pos_t          digit
    );
        pos_t len;
        pos_t n;
        pos_t idx;
        len          = pos_t'(msg_len(msg));
        n            = len + pos_t'(DIGITS);
        idx          = pos + digit;
        render_digit = SEG_OFF;
        case (st)
            SHOW_R, BLINK_R: begin
                if (st == SHOW_R || visible) begin
                    if (msg == STOPWATCH_MSG) begin
                        render_digit = bcd_to_seg(bcd);
                    end else if (digit < len) begin
                        render_digit = msg_char(msg, digit[2:0]);
                    end
                end
            end
            SCROLL_R: begin
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (idx < len) begin
                    render_digit = msg_char(msg, idx[2:0]);
                end
            end
            default: render_digit = SEG_OFF;
        endcase
    endfunction

    assign last_pos = pos_t'(msg_len(msg_q)) + pos_t'(DIGITS - 1);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        msg_d     = msg_q;
        pos_d     = pos_q;
        visible_d = visible_q;
        wrap_d    = 1'b0;
        if (load_i) begin
            state_d   = state_for(msg_i, mode_i);
            msg_d     = msg_i;
            pos_d     = '0;
            visible_d = 1'b1;
        end else if (tick) begin
            case (state_q)
                BLINK_R: visible_d = ~visible_q;
                SCROLL_R: begin
                    if (pos_q == last_pos) begin
                        pos_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        pos_d = pos_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Render from next-state values so load and tick effects reach seg_o one cycle later.
    always_comb begin
        seg_d = '1;
        for (int i = 0; i < DIGITS; i++) begin
            seg_d[7*i +: 7] = render_digit(state_d, msg_d, visible_d, pos_d, bcd_i[4*i +: 4], pos_t'(i));
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q   <= IDLE_R;
            msg_q     <= EMPTY;
            pos_q     <= '0;
            visible_q <= 1'b1;
            seg_o     <= '1;
            busy_o    <= 1'b0;
            wrap_o    <= 1'b0;
        end else begin
            state_q   <= state_d;
            msg_q     <= msg_d;
            pos_q     <= pos_d;
            visible_q <= visible_d;
            seg_o     <= seg_d;
            busy_o    <= (state_d == SCROLL_R);
            wrap_o    <= wrap_d;
        end
    end

endmodule

// File: tb/tb_seg_msg_renderer.sv
// Directed self-checking bench for seg_msg_renderer with DIGITS=6, TICK_DIV=4.
module tb_seg_msg_renderer;
    import datatype_package::*;

    localparam int DIGITS   = 6;
    localparam int TICK_DIV = 4;

    localparam seg_symbol_t WIN_V [11] = '{SEG_G, SEG_R, SEG_E, SEG_A, SEG_T,
                                           SEG_OFF, SEG_OFF, SEG_OFF, SEG_OFF, SEG_OFF, SEG_OFF};

    logic                clk = 1'b0;
    logic                srst = 1'b1;
    msg_t                msg = EMPTY;
    disp_mode_t          mode = MODE_STATIC;
    logic                load = 1'b0;
    logic [4*DIGITS-1:0] bcd = '0;
    logic [7*DIGITS-1:0] seg;
    logic                busy;
    logic                wrap;

    int checks = 0;
    int errors = 0;

    seg_msg_renderer #(
        .DIGITS  (DIGITS),
        .TICK_DIV(TICK_DIV)
    ) dut (
        .clk_i (clk),
        .srst_i(srst),
        .msg_i (msg),
        .mode_i(mode),
        .load_i(load),
        .bcd_i (bcd),
        .seg_o (seg),
        .busy_o(busy),
        .wrap_o(wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [41:0] obs, input logic [41:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input msg_t m, input disp_mode_t md);
        msg  = m;
        mode = md;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    function automatic logic [41:0] pack(input seg_symbol_t d0, d1, d2, d3, d4, d5);
        return {d5, d4, d3, d2, d1, d0};
    endfunction

    function automatic logic [41:0] win_window(input int p);
        logic [41:0] r;
        for (int i = 0; i < 6; i++) r[7*i +: 7] = WIN_V[(p + i) % 11];
        return r;
    endfunction

    localparam logic [41:0] ALL_OFF = {42{1'b1}};

    initial begin
        logic [41:0] exp_seg;

        // Reset state, then hold without any load.
        step();
        step();
        check("reset seg", seg, ALL_OFF);
        check("reset busy", {41'd0, busy}, 42'd0);
        check("reset wrap", {41'd0, wrap}, 42'd0);
        srst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("idle seg k=%0d", k), seg, ALL_OFF);
        end

        // WIN static: G,R,E,A,T,OFF, stable for 40 cycles.
        do_load(WIN, MODE_STATIC);
        exp_seg = pack(SEG_G, SEG_R, SEG_E, SEG_A, SEG_T, SEG_OFF);
        for (int k = 0; k < 40; k++) begin
            check($sformatf("win static seg k=%0d", k), seg, exp_seg);
            step();
        end
        check("win static busy", {41'd0, busy}, 42'd0);

        // READY blink: dashes 4 cycles, off 4 cycles, alternating.
        do_load(READY, MODE_BLINK);
        for (int k = 0; k < 16; k++) begin
            exp_seg = ((k / 4) % 2 == 0) ? pack(SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH)
                                         : ALL_OFF;
            check($sformatf("ready blink seg k=%0d", k), seg, exp_seg);
            check($sformatf("ready blink busy k=%0d", k), {41'd0, busy}, 42'd0);
            step();
        end

        // WIN scroll: window steps every 4 cycles, wrap 44 cycles after load.
        do_load(WIN, MODE_SCROLL);
        for (int k = 0; k < 50; k++) begin
            check($sformatf("win scroll seg k=%0d", k), seg, win_window((k / 4) % 11));
            check($sformatf("win scroll wrap k=%0d", k), {41'd0, wrap}, {41'd0, (k == 44)});
            check($sformatf("win scroll busy k=%0d", k), {41'd0, busy}, 42'd1);
            step();
        end

        // Stopwatch: live BCD decode with one-cycle latency; invalid nibble shows a dash.
        bcd = 24'h012345;
        do_load(STOPWATCH_MSG, MODE_STATIC);
        check("stopwatch seg", seg, pack(SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0));
        bcd = 24'h01234A;
        step();
        check("stopwatch dash", seg, pack(SEG_DASH, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0));
        bcd = 24'h987654;
        step();
        check("stopwatch update", seg, pack(SEG_4, SEG_5, SEG_6, SEG_7, SEG_8, SEG_9));

        // Stopwatch ignores scroll: static, not busy, no wrap.
        do_load(STOPWATCH_MSG, MODE_SCROLL);
        for (int k = 0; k < 48; k++) begin
            check($sformatf("stopwatch scroll wrap k=%0d", k), {41'd0, wrap}, 42'd0);
            step();
        end
        check("stopwatch scroll seg", seg, pack(SEG_4, SEG_5, SEG_6, SEG_7, SEG_8, SEG_9));
        check("stopwatch scroll busy", {41'd0, busy}, 42'd0);

        // Load WELCOME in the cycle a wrap is due: wrap suppressed.
        do_load(WIN, MODE_SCROLL);
        for (int k = 1; k < 44; k++) begin
            step();
            check($sformatf("pre-wrap wrap k=%0d", k), {41'd0, wrap}, 42'd0);
        end
        do_load(WELCOME, MODE_STATIC);
        exp_seg = pack(SEG_G, SEG_E, SEG_T, SEG_OFF, SEG_U, SEG_P);
        check("suppress wrap", {41'd0, wrap}, 42'd0);
        check("welcome seg", seg, exp_seg);
        check("welcome busy", {41'd0, busy}, 42'd0);
        for (int k = 0; k < 12; k++) begin
            step();
            check($sformatf("welcome hold k=%0d", k), seg, exp_seg);
        end

        // EMPTY with scroll: blank, idle, never wraps.
        do_load(EMPTY, MODE_SCROLL);
        for (int k = 0; k < 48; k++) begin
            check($sformatf("empty seg k=%0d", k), seg, ALL_OFF);
            check($sformatf("empty wrap k=%0d", k), {41'd0, wrap}, 42'd0);
            step();
        end
        check("empty busy", {41'd0, busy}, 42'd0);

        // Reset in the middle of a scroll returns to the reset state.
        do_load(WIN, MODE_SCROLL);
        for (int k = 0; k < 6; k++) step();
        srst = 1'b1;
        step();
        check("mid reset seg", seg, ALL_OFF);
        check("mid reset busy", {41'd0, busy}, 42'd0);
        srst = 1'b0;
        step();
        check("post reset seg", seg, ALL_OFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
